// File: rtl/rv32im_csr_ctrl.sv
`timescale 1ns/1ps
// rv32im_csr_ctrl: turns Zicsr instructions, trap entry and MRET into
// read/write sequences on the single-port CSR file, one requester at a time.
module rv32im_csr_ctrl #(
    parameter int XLEN = 32,
    parameter int AW   = 12
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            instr_req_i,
    input  logic [2:0]      instr_op_i,
    input  logic [AW-1:0]   instr_addr_i,
    input  logic [XLEN-1:0] instr_src_i,
    input  logic            instr_src_zero_i,
    output logic            instr_done_o,
    output logic [XLEN-1:0] instr_rdata_o,
    output logic            instr_illegal_o,
    input  logic            trap_req_i,
    input  logic [XLEN-1:0] trap_pc_i,
    input  logic [XLEN-1:0] trap_cause_i,
    input  logic [XLEN-1:0] trap_tval_i,
    output logic            trap_done_o,
    output logic [XLEN-1:0] trap_vec_o,
    input  logic            mret_req_i,
    output logic            mret_done_o,
    output logic [XLEN-1:0] mret_pc_o,
    output logic            busy_o,
    output logic [AW-1:0]   csr_addr_o,
    output logic [XLEN-1:0] csr_wdata_o,
    output logic            csr_we_o,
    output logic            csr_re_o,
    input  logic [XLEN-1:0] csr_rdata_i
);
    localparam logic [AW-1:0] CSR_MSTATUS = AW'(12'h300);
    localparam logic [AW-1:0] CSR_MTVEC   = AW'(12'h305);
    localparam logic [AW-1:0] CSR_MEPC    = AW'(12'h341);
    localparam logic [AW-1:0] CSR_MCAUSE  = AW'(12'h342);
    localparam logic [AW-1:0] CSR_MTVAL   = AW'(12'h343);

    // Low two opcode bits select the operation; bit 2 (immediate form) only
    // changes where the source came from, which the pipeline already resolved.
    localparam logic [1:0] OP_RW = 2'b01;
    localparam logic [1:0] OP_RS = 2'b10;
    localparam logic [1:0] OP_RC = 2'b11;

    typedef enum logic [3:0] {
        S_IDLE, S_I_RD, S_I_WB,
        S_T_EPC, S_T_CAUSE, S_T_TVAL, S_T_RDST, S_T_WRST, S_T_RDVEC, S_T_DONE,
        S_M_RDST, S_M_WRST, S_M_RDEPC, S_M_DONE
    } state_t;

    state_t          state, state_next;
    logic [1:0]      op_q;
    logic [AW-1:0]   addr_q;
    logic [XLEN-1:0] src_q;
    logic            src_zero_q;
    logic [XLEN-1:0] pc_q, cause_q, tval_q;
    logic [XLEN-1:0] instr_new;
    logic            instr_wants_write;
    logic            instr_ro;
    logic            unused_op_imm;

    assign unused_op_imm = instr_op_i[2];

    // Trap entry: stack MIE into MPIE, disable interrupts, previous mode M.
    function automatic logic [XLEN-1:0] trap_mstatus(input logic [XLEN-1:0] s);
        logic [XLEN-1:0] r;
        r        = s;
        r[7]     = s[3];
        r[3]     = 1'b0;
        r[12:11] = 2'b11;
        return r;
    endfunction

    // MRET: restore MIE from MPIE, set MPIE, previous mode stays M.
    function automatic logic [XLEN-1:0] mret_mstatus(input logic [XLEN-1:0] s);
        logic [XLEN-1:0] r;
        r        = s;
        r[3]     = s[7];
        r[7]     = 1'b1;
        r[12:11] = 2'b11;
        return r;
    endfunction

    // State register
    always_ff @(posedge clk_i) begin
        if (rst_i) state <= S_IDLE;
        else       state <= state_next;
    end

    // Capture the winning requester's fields at accept; ignored afterwards
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            op_q       <= '0;
            addr_q     <= '0;
            src_q      <= '0;
            src_zero_q <= 1'b0;
            pc_q       <= '0;
            cause_q    <= '0;
            tval_q     <= '0;
        end else if (state == S_IDLE) begin
            if (trap_req_i) begin
                pc_q    <= trap_pc_i;
                cause_q <= trap_cause_i;
                tval_q  <= trap_tval_i;
            end else if (!mret_req_i && instr_req_i) begin
                op_q       <= instr_op_i[1:0];
                addr_q     <= instr_addr_i;
                src_q      <= instr_src_i;
                src_zero_q <= instr_src_zero_i;
            end
        end
    end

    // Next-state logic: fixed-priority arbitration in IDLE, linear sequences otherwise
    always_comb begin
        state_next = S_IDLE;
        case (state)
            S_IDLE: begin
                if (trap_req_i)       state_next = S_T_EPC;
                else if (mret_req_i)  state_next = S_M_RDST;
                else if (instr_req_i) state_next = S_I_RD;
                else                  state_next = S_IDLE;
            end
            S_I_RD:    state_next = S_I_WB;
            S_I_WB:    state_next = S_IDLE;
            S_T_EPC:   state_next = S_T_CAUSE;
            S_T_CAUSE: state_next = S_T_TVAL;
            S_T_TVAL:  state_next = S_T_RDST;
            S_T_RDST:  state_next = S_T_WRST;
            S_T_WRST:  state_next = S_T_RDVEC;
            S_T_RDVEC: state_next = S_T_DONE;
            S_T_DONE:  state_next = S_IDLE;
            S_M_RDST:  state_next = S_M_WRST;
            S_M_WRST:  state_next = S_M_RDEPC;
            S_M_RDEPC: state_next = S_M_DONE;
            S_M_DONE:  state_next = S_IDLE;
            default:   state_next = S_IDLE;
        endcase
    end

    // Read-modify-write value and write qualification for the instruction flow
    always_comb begin
        instr_new = csr_rdata_i;
        case (op_q)
            OP_RW:   instr_new = src_q;
            OP_RS:   instr_new = csr_rdata_i | src_q;
            OP_RC:   instr_new = csr_rdata_i & ~src_q;
            default: instr_new = csr_rdata_i;
        endcase
        instr_wants_write = (op_q != 2'b00) && !(op_q[1] && src_zero_q);
        instr_ro          = (addr_q[AW-1 -: 2] == 2'b11);
    end

    // Output decode; everything is held low during reset so no write escapes
    always_comb begin
        csr_addr_o      = '0;
        csr_wdata_o     = '0;
        csr_we_o        = 1'b0;
        csr_re_o        = 1'b0;
        instr_done_o    = 1'b0;
        instr_rdata_o   = '0;
        instr_illegal_o = 1'b0;
        trap_done_o     = 1'b0;
        trap_vec_o      = '0;
        mret_done_o     = 1'b0;
        mret_pc_o       = '0;
        busy_o          = 1'b0;
        if (!rst_i) begin
            busy_o = (state != S_IDLE);
            case (state)
                S_I_RD: begin
                    csr_addr_o = addr_q;
                    csr_re_o   = 1'b1;
                end
                S_I_WB: begin
                    csr_addr_o      = addr_q;
                    csr_wdata_o     = instr_new;
                    csr_we_o        = instr_wants_write && !instr_ro;
                    instr_illegal_o = instr_wants_write && instr_ro;
                    instr_done_o    = 1'b1;
                    instr_rdata_o   = csr_rdata_i;
                end
                S_T_EPC: begin
                    csr_addr_o  = CSR_MEPC;
                    csr_wdata_o = pc_q;
                    csr_we_o    = 1'b1;
                end
                S_T_CAUSE: begin
                    csr_addr_o  = CSR_MCAUSE;
                    csr_wdata_o = cause_q;
                    csr_we_o    = 1'b1;
                end
                S_T_TVAL: begin
                    csr_addr_o  = CSR_MTVAL;
                    csr_wdata_o = tval_q;
                    csr_we_o    = 1'b1;
                end
                S_T_RDST, S_M_RDST: begin
                    csr_addr_o = CSR_MSTATUS;
                    csr_re_o   = 1'b1;
                end
                S_T_WRST: begin
                    csr_addr_o  = CSR_MSTATUS;
                    csr_wdata_o = trap_mstatus(csr_rdata_i);
                    csr_we_o    = 1'b1;
                end
                S_T_RDVEC: begin
                    csr_addr_o = CSR_MTVEC;
                    csr_re_o   = 1'b1;
                end
                S_T_DONE: begin
                    trap_done_o = 1'b1;
                    trap_vec_o  = {csr_rdata_i[XLEN-1:2], 2'b00};
                end
                S_M_WRST: begin
                    csr_addr_o  = CSR_MSTATUS;
                    csr_wdata_o = mret_mstatus(csr_rdata_i);
                    csr_we_o    = 1'b1;
                end
                S_M_RDEPC: begin
                    csr_addr_o = CSR_MEPC;
                    csr_re_o   = 1'b1;
                end
                S_M_DONE: begin
                    mret_done_o = 1'b1;
                    mret_pc_o   = csr_rdata_i;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_rv32im_csr_ctrl.sv
`timescale 1ns/1ps
// Testbench for rv32im_csr_ctrl: behavioural CSR file plus a response scoreboard.
module tb_rv32im_csr_ctrl;
    localparam int XLEN = 32;
    localparam int AW   = 12;

    logic            clk = 1'b0;
    logic            rst_i;
    logic            instr_req_i;
    logic [2:0]      instr_op_i;
    logic [AW-1:0]   instr_addr_i;
    logic [XLEN-1:0] instr_src_i;
    logic            instr_src_zero_i;
    logic            instr_done_o;
    logic [XLEN-1:0] instr_rdata_o;
    logic            instr_illegal_o;
    logic            trap_req_i;
    logic [XLEN-1:0] trap_pc_i, trap_cause_i, trap_tval_i;
    logic            trap_done_o;
    logic [XLEN-1:0] trap_vec_o;
    logic            mret_req_i;
    logic            mret_done_o;
    logic [XLEN-1:0] mret_pc_o;
    logic            busy_o;
    logic [AW-1:0]   csr_addr_o;
    logic [XLEN-1:0] csr_wdata_o;
    logic            csr_we_o, csr_re_o;
    logic [XLEN-1:0] csr_rdata_i;

    always #5 clk = ~clk;

    rv32im_csr_ctrl #(.XLEN(XLEN), .AW(AW)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .instr_req_i(instr_req_i), .instr_op_i(instr_op_i), .instr_addr_i(instr_addr_i),
        .instr_src_i(instr_src_i), .instr_src_zero_i(instr_src_zero_i),
        .instr_done_o(instr_done_o), .instr_rdata_o(instr_rdata_o),
        .instr_illegal_o(instr_illegal_o),
        .trap_req_i(trap_req_i), .trap_pc_i(trap_pc_i), .trap_cause_i(trap_cause_i),
        .trap_tval_i(trap_tval_i), .trap_done_o(trap_done_o), .trap_vec_o(trap_vec_o),
        .mret_req_i(mret_req_i), .mret_done_o(mret_done_o), .mret_pc_o(mret_pc_o),
        .busy_o(busy_o), .csr_addr_o(csr_addr_o), .csr_wdata_o(csr_wdata_o),
        .csr_we_o(csr_we_o), .csr_re_o(csr_re_o), .csr_rdata_i(csr_rdata_i)
    );

    // Behavioural single-port CSR file: registered read data, preload port for the bench
    logic [31:0] mem [0:4095];
    logic        pl_en = 1'b0;
    logic [11:0] pl_addr;
    logic [31:0] pl_data;

    always @(posedge clk) begin
        if (pl_en) mem[pl_addr] <= pl_data;
        else if (csr_we_o) mem[csr_addr_o] <= csr_wdata_o;
        if (csr_re_o) csr_rdata_i <= mem[csr_addr_o];
    end

    typedef struct {
        int          kind;      // 0 instr, 1 trap, 2 mret
        logic [31:0] data;
        logic        illegal;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   errors   = 0;
    int   we_count = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, req);
        end
    endtask

    task automatic push(input int kind, input logic [31:0] data, input logic illegal);
        exp_t e;
        e.kind = kind; e.data = data; e.illegal = illegal;
        exp_q.push_back(e);
    endtask

    // Monitor: pops one expectation per completion pulse, watches port exclusivity
    always @(negedge clk) begin
        exp_t e;
        int   act_kind;
        if (csr_we_o) we_count++;
        check("we/re exclusive", 32'(csr_we_o & csr_re_o), 32'd0);
        if (instr_done_o || trap_done_o || mret_done_o) begin
            act_kind = trap_done_o ? 1 : (mret_done_o ? 2 : 0);
            check("single done pulse", 32'(instr_done_o + trap_done_o + mret_done_o), 32'd1);
            if (exp_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected done: kind %0d with empty scoreboard", act_kind);
            end else begin
                e = exp_q.pop_front();
                check("done kind", 32'(act_kind), 32'(e.kind));
                case (e.kind)
                    0: begin
                        check("instr rdata", instr_rdata_o, e.data);
                        check("instr illegal", 32'(instr_illegal_o), 32'(e.illegal));
                    end
                    1: check("trap vec", trap_vec_o, e.data);
                    default: check("mret pc", mret_pc_o, e.data);
                endcase
            end
        end
    end

    task automatic preload(input logic [11:0] a, input logic [31:0] d);
        pl_en = 1'b1; pl_addr = a; pl_data = d;
        @(posedge clk); #1;
        pl_en = 1'b0;
    endtask

    task automatic set_instr(input logic [2:0] op, input logic [11:0] a,
                             input logic [31:0] src, input logic zero);
        instr_op_i = op; instr_addr_i = a; instr_src_i = src; instr_src_zero_i = zero;
    endtask

    task automatic set_trap(input logic [31:0] pc, input logic [31:0] cause, input logic [31:0] tval);
        trap_pc_i = pc; trap_cause_i = cause; trap_tval_i = tval;
    endtask

    // Raise one request, hold it until its done pulse, check cycles from raise
    task automatic run_req(input int kind, input int exp_n, input string name);
        int   n    = 0;
        logic seen = 1'b0;
        case (kind)
            0:       instr_req_i = 1'b1;
            1:       trap_req_i  = 1'b1;
            default: mret_req_i  = 1'b1;
        endcase
        while (n < 40 && !seen) begin
            @(negedge clk);
            n++;
            case (kind)
                0:       seen = instr_done_o;
                1:       seen = trap_done_o;
                default: seen = mret_done_o;
            endcase
        end
        case (kind)
            0:       instr_req_i = 1'b0;
            1:       trap_req_i  = 1'b0;
            default: mret_req_i  = 1'b0;
        endcase
        if (!seen) begin
            checks++; errors++;
            $display("FAIL %s timeout: no done within %0d cycles, expected at %0d", name, n, exp_n);
        end else begin
            check({name, " latency"}, 32'(n), 32'(exp_n));
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic any_out;
        rst_i = 1'b1;
        instr_req_i = 1'b0; trap_req_i = 1'b0; mret_req_i = 1'b0;
        set_instr(3'b000, 12'h000, 32'h0, 1'b0);
        set_trap(32'h0, 32'h0, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        any_out = instr_done_o | instr_illegal_o | trap_done_o | mret_done_o | busy_o |
                  csr_we_o | csr_re_o | (|instr_rdata_o) | (|trap_vec_o) | (|mret_pc_o) |
                  (|csr_addr_o) | (|csr_wdata_o);
        check("reset outputs", 32'(any_out), 32'd0);
        rst_i = 1'b0;
        @(posedge clk); #1;

        // CSRRS on MSTATUS sets MPP
        preload(12'h300, 32'h0000_0088);
        set_instr(3'b010, 12'h300, 32'h0000_1800, 1'b0);
        push(0, 32'h0000_0088, 1'b0);
        run_req(0, 3, "csrrs");
        @(posedge clk); #1;
        check("csrrs mstatus", mem[12'h300], 32'h0000_1888);

        // CSRRC with rs1=x0 must not write
        we_count = 0;
        set_instr(3'b011, 12'h300, 32'h0000_0008, 1'b1);
        push(0, 32'h0000_1888, 1'b0);
        run_req(0, 3, "csrrc zero");
        @(posedge clk); #1;
        check("csrrc zero writes", 32'(we_count), 32'd0);
        check("csrrc zero mstatus", mem[12'h300], 32'h0000_1888);

        // CSRRW to a read-only counter is illegal and suppressed
        preload(12'hC00, 32'h1234_5678);
        we_count = 0;
        set_instr(3'b001, 12'hC00, 32'h0000_DEAD, 1'b0);
        push(0, 32'h1234_5678, 1'b1);
        run_req(0, 3, "csrrw ro");
        @(posedge clk); #1;
        check("csrrw ro writes", 32'(we_count), 32'd0);
        check("csrrw ro value", mem[12'hC00], 32'h1234_5678);

        // CSRRC with nonzero source clears MIE
        set_instr(3'b011, 12'h300, 32'h0000_0008, 1'b0);
        push(0, 32'h0000_1888, 1'b0);
        run_req(0, 3, "csrrc");
        @(posedge clk); #1;
        check("csrrc mstatus", mem[12'h300], 32'h0000_1880);

        // CSRRWI on MSCRATCH
        preload(12'h340, 32'h0000_0005);
        set_instr(3'b101, 12'h340, 32'h0000_001F, 1'b0);
        push(0, 32'h0000_0005, 1'b0);
        run_req(0, 3, "csrrwi");
        @(posedge clk); #1;
        check("csrrwi mscratch", mem[12'h340], 32'h0000_001F);

        // Trap entry
        preload(12'h300, 32'h0000_0008);
        preload(12'h305, 32'h0000_8001);
        preload(12'h343, 32'h0000_FFFF);
        set_trap(32'h0000_0100, 32'h0000_000B, 32'h0000_0000);
        push(1, 32'h0000_8000, 1'b0);
        run_req(1, 8, "trap");
        @(posedge clk); #1;
        check("trap mepc", mem[12'h341], 32'h0000_0100);
        check("trap mcause", mem[12'h342], 32'h0000_000B);
        check("trap mtval", mem[12'h343], 32'h0000_0000);
        check("trap mstatus", mem[12'h300], 32'h0000_1880);

        // MRET
        push(2, 32'h0000_0100, 1'b0);
        run_req(2, 5, "mret");
        @(posedge clk); #1;
        check("mret mstatus", mem[12'h300], 32'h0000_1888);

        // All three requesters at once: trap, then mret, then instr
        set_trap(32'h0000_0200, 32'h0000_0003, 32'h0000_0044);
        set_instr(3'b001, 12'h340, 32'h0000_ABCD, 1'b0);
        push(1, 32'h0000_8000, 1'b0);
        push(2, 32'h0000_0200, 1'b0);
        push(0, 32'h0000_001F, 1'b0);
        fork
            run_req(1, 8, "arb trap");
            run_req(2, 13, "arb mret");
            run_req(0, 16, "arb instr");
        join
        @(posedge clk); #1;
        check("arb mstatus", mem[12'h300], 32'h0000_1888);
        check("arb mepc", mem[12'h341], 32'h0000_0200);
        check("arb mtval", mem[12'h343], 32'h0000_0044);
        check("arb mscratch", mem[12'h340], 32'h0000_ABCD);

        // Reset while in T_TVAL abandons the trap
        preload(12'h300, 32'h0000_0008);
        preload(12'h341, 32'h0000_0000);
        preload(12'h342, 32'h0000_0000);
        preload(12'h343, 32'h0000_0077);
        set_trap(32'h0000_0300, 32'h0000_0007, 32'h0000_0099);
        trap_req_i = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst_i = 1'b1;
        trap_req_i = 1'b0;
        @(posedge clk); #1;
        rst_i = 1'b0;
        check("rst busy", 32'(busy_o), 32'd0);
        repeat (10) @(posedge clk);
        #1;
        check("rst mstatus", mem[12'h300], 32'h0000_0008);
        check("rst mtval", mem[12'h343], 32'h0000_0077);
        check("rst mepc", mem[12'h341], 32'h0000_0300);
        check("rst mcause", mem[12'h342], 32'h0000_0007);
        check("scoreboard drained", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
